// File: rtl/bank_reader.sv
// ---------------------------------------------------------------------------
// bank_reader
//   Turns a (start address, length, mux code) command into a run of
//   single-cycle bank reads. The read data is streamed out through a
//   valid/ready handshake. A 2-entry skid FIFO with credit-based issue
//   allows the stream to run at 1 word/cycle, and the FIFO cannot overflow
//   whatever the consumer does.
//
// Parameters
//   W : data word width
//   A : bank address width
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only when idle)
//   cmd_addr, cmd_len    : start word address, word count (0..2^A)
//   cmd_mux              : bank read mux code for the whole command
//   cmd_stride           : address increment (only with BANK_READER_STRIDE_EN)
//   rd_en, rd_addr       : bank read strobe and address
//   rd_muxcode           : latched mux code while busy, 0 when idle
//   rd_word              : bank data, valid one cycle after rd_en
//   out_valid/out_ready  : output stream handshake
//   out_data, out_last   : stream word and end-of-command marker
//   busy                 : high whenever not idle
//
// Configuration macro
//   BANK_READER_STRIDE_EN : adds cmd_stride. When it is not defined, the
//                           stride is fixed at 1.
// ---------------------------------------------------------------------------
module bank_reader #(
    parameter int W = 64,
    parameter int A = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [A-1:0] cmd_addr,
    input  logic [A:0]   cmd_len,
    input  logic [1:0]   cmd_mux,
`ifdef BANK_READER_STRIDE_EN
    input  logic [A-1:0] cmd_stride,
`endif
    output logic         rd_en,
    output logic [A-1:0] rd_addr,
    output logic [1:0]   rd_muxcode,
    input  logic [W-1:0] rd_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [A:0] LEN_ONE  = (A+1)'(1);

    logic [1:0]   state_q, state_d;
    logic [A-1:0] addr_q, addr_d;
    logic [A:0]   rem_q, rem_d;
    logic [1:0]   mux_q, mux_d;
    logic [A-1:0] stride;
    logic         inflight_q, inflight_d;
    logic         inflight_last_q, inflight_last_d;
    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [W-1:0] entry_data [2];
    logic [1:0]   entry_last;
    logic         push, pop, issue, credit, last_issue;
    logic [2:0]   occupancy;

`ifdef BANK_READER_STRIDE_EN
    logic [A-1:0] stride_q, stride_d;
    assign stride = stride_q;
`else
    assign stride = A'(1);
`endif

    // Handshake and credit. Occupancy counts the words stored plus the one
    // read still in flight. A word that leaves this cycle frees its slot at
    // once, so with out_ready held high the block can issue every cycle.
    assign out_valid  = (count_q != 2'd0);
    assign pop        = out_valid & out_ready;
    assign push       = inflight_q;
    assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
    assign credit     = (occupancy - {2'b00, pop}) < 3'd2;
    assign issue      = (state_q == ST_RUN) && credit;
    assign last_issue = issue && (rem_q == LEN_ONE);

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rd_en      = issue;
    assign rd_addr    = addr_q;
    assign rd_muxcode = busy ? mux_q : 2'b00;
    assign out_data   = out_valid ? entry_data[rd_ptr_q] : '0;
    assign out_last   = out_valid & entry_last[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        mux_d   = mux_q;
`ifdef BANK_READER_STRIDE_EN
        stride_d = stride_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    mux_d  = cmd_mux;
`ifdef BANK_READER_STRIDE_EN
                    stride_d = cmd_stride;
`endif
                    // An empty command is accepted and dropped.
                    if (cmd_len != '0) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_q + stride;
                    rem_d  = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Only the final word carries last, so when it transfers
                // nothing is in flight and the FIFO becomes empty.
                if (pop && out_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inflight_d      = issue;
        inflight_last_d = last_issue;
        wr_ptr_d        = wr_ptr_q ^ push;
        rd_ptr_d        = rd_ptr_q ^ pop;
        count_d         = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage: each entry is written when a returning read targets it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
            logic [W-1:0] data_q, data_d;
            logic         last_q, last_d;

            always_comb begin
                data_d = data_q;
                last_d = last_q;
                if (push && (wr_ptr_q == 1'(gi))) begin
                    data_d = rd_word;
                    last_d = inflight_last_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                    last_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    last_q <= last_d;
                end
            end

            assign entry_data[gi] = data_q;
            assign entry_last[gi] = last_q;
        end
    endgenerate

    // Clearing inflight on reset discards any read outstanding at reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            mux_q           <= 2'b00;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            mux_q           <= mux_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
        end
    end

`ifdef BANK_READER_STRIDE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= '0;
        end else begin
            stride_q <= stride_d;
        end
    end
`endif

endmodule

// File: tb/tb_bank_reader.sv
// ---------------------------------------------------------------------------
// tb_bank_reader
//   Self-checking bench for bank_reader. A behavioural bank returns a salted
//   function of the read address. Expected streams are built from the
//   command alone: address i = base + i*stride mod 2^A, data = bank(address),
//   and last is set on the final word.
// ---------------------------------------------------------------------------
module tb_bank_reader;
    localparam int W = 64;
    localparam int A = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [A-1:0] cmd_addr = '0;
    logic [A:0]   cmd_len = '0;
    logic [1:0]   cmd_mux = 2'b00;
`ifdef BANK_READER_STRIDE_EN
    logic [A-1:0] cmd_stride = '0;
`endif
    logic         rd_en;
    logic [A-1:0] rd_addr;
    logic [1:0]   rd_muxcode;
    logic [W-1:0] rd_word = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] salt = 32'h1234_5678;

    always #5 clk = ~clk;

    bank_reader #(.W(W), .A(A)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_mux(cmd_mux),
`ifdef BANK_READER_STRIDE_EN
        .cmd_stride(cmd_stride),
`endif
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_muxcode(rd_muxcode),
        .rd_word(rd_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    function automatic logic [W-1:0] bank_val(input logic [A-1:0] a, input logic [31:0] s);
        return {s, 32'(a) ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [A-1:0] model_addr(input int base, input int stride, input int i);
        return A'((base + i * stride) % (1 << A));
    endfunction

    // Behavioural bank: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_word <= bank_val(rd_addr, salt);
    end

    // Observations collected by run_cmd and checked by each test.
    logic [A-1:0] obs_addr[$];
    int           obs_rd_cyc[$];
    logic [W-1:0] obs_data[$];
    logic         obs_last[$];
    int           obs_out_cyc[$];
    int           stall_err, mux_err, idle_err, done_cyc;
    bit           timed_out, accepted_ok;
    logic [A-1:0] cur_stride;

    // mode 0: out_ready=1, mode 1: 1,0,0,1 repeating, mode 2: random
    task automatic run_cmd(input logic [A-1:0] addr, input logic [A:0] len,
                           input logic [1:0] mux, input logic [A-1:0] stride,
                           input int mode, input int max_cyc);
        int cyc;
        logic pv, pr, pl;
        logic [W-1:0] pd;
        obs_addr.delete(); obs_rd_cyc.delete(); obs_data.delete();
        obs_last.delete(); obs_out_cyc.delete();
        stall_err = 0; mux_err = 0; idle_err = 0; done_cyc = -1;
        timed_out = 1'b0;
        cur_stride = stride;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_mux = mux;
`ifdef BANK_READER_STRIDE_EN
        cmd_stride = cur_stride;
`endif
        out_ready = 1'b1;
        #1 accepted_ok = cmd_ready;
        pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (rd_en) begin
                obs_addr.push_back(rd_addr);
                obs_rd_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                obs_data.push_back(out_data);
                obs_last.push_back(out_last);
                obs_out_cyc.push_back(cyc);
            end
            if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) stall_err++;
            if (busy && rd_muxcode !== mux) mux_err++;
            if (!busy && (rd_en || out_valid || rd_muxcode != 2'b00 || !cmd_ready)) idle_err++;
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            if (!busy) begin
                done_cyc = cyc;
                break;
            end
            if (cyc >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (rd_en !== 1'b0 || rd_addr !== '0 || rd_muxcode !== 2'b00 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || out_data !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_outputs: got rd_en=%b rd_addr=%h mux=%h ov=%b ol=%b od=%h busy=%b crdy=%b required 0,0,0,0,0,0,0,1",
                     rd_en, rd_addr, rd_muxcode, out_valid, out_last, out_data, busy, cmd_ready);
        end
        $display("reset: outputs sampled after release");
    endtask

    task automatic test_basic();
        salt = $urandom;
        run_cmd(10'h010, 11'd4, 2'd3, 10'd1, 0, 100);
        compared++;
        if (timed_out || !accepted_ok) begin mismatched++; $display("FAIL basic_done: timeout=%b accepted=%b required 0/1", timed_out, accepted_ok); end
        compared++;
        if (obs_addr.size() != 4 || obs_data.size() != 4) begin
            mismatched++; $display("FAIL basic_count: reads=%0d words=%0d required 4/4", obs_addr.size(), obs_data.size());
        end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            compared++;
            if (obs_addr[i] !== model_addr(16, 1, i) || obs_rd_cyc[i] != 1 + i) begin
                mismatched++; $display("FAIL basic_rd[%0d]: got addr %h cyc %0d required %h cyc %0d", i, obs_addr[i], obs_rd_cyc[i], model_addr(16, 1, i), 1 + i);
            end
        end
        for (int i = 0; i < obs_data.size() && i < 4; i++) begin
            compared++;
            if (obs_data[i] !== bank_val(model_addr(16, 1, i), salt) || obs_last[i] !== (i == 3) || obs_out_cyc[i] != 3 + i) begin
                mismatched++; $display("FAIL basic_out[%0d]: got %h last %b cyc %0d required %h last %b cyc %0d", i, obs_data[i], obs_last[i], obs_out_cyc[i],
                                       bank_val(model_addr(16, 1, i), salt), (i == 3), 3 + i);
            end
        end
        compared++;
        if (done_cyc != 7 || mux_err != 0 || idle_err != 0) begin
            mismatched++; $display("FAIL basic_busy: busy fell at %0d mux_err %0d idle_err %0d required 7/0/0", done_cyc, mux_err, idle_err);
        end
        $display("basic: addr=010 len=4 reads=%0d words=%0d done=%0d", obs_addr.size(), obs_data.size(), done_cyc);
    endtask

    task automatic test_wrap();
        salt = $urandom;
        run_cmd(10'h3FE, 11'd4, 2'd1, 10'd1, 0, 100);
        compared++;
        if (timed_out || obs_addr.size() != 4 || obs_data.size() != 4) begin
            mismatched++; $display("FAIL wrap_count: timeout=%b reads=%0d words=%0d required 0/4/4", timed_out, obs_addr.size(), obs_data.size());
        end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            compared++;
            if (obs_addr[i] !== model_addr(1022, 1, i)) begin
                mismatched++; $display("FAIL wrap_addr[%0d]: got %h required %h", i, obs_addr[i], model_addr(1022, 1, i));
            end
        end
        for (int i = 0; i < obs_data.size() && i < 4; i++) begin
            compared++;
            if (obs_data[i] !== bank_val(model_addr(1022, 1, i), salt)) begin
                mismatched++; $display("FAIL wrap_data[%0d]: got %h required %h", i, obs_data[i], bank_val(model_addr(1022, 1, i), salt));
            end
        end
        $display("wrap: addr=3FE len=4 reads=%0d", obs_addr.size());
    endtask

    task automatic test_stall();
        int base;
        base = $urandom_range(0, 1023);
        salt = $urandom;
        run_cmd(A'(base), 11'd8, 2'd2, 10'd1, 1, 200);
        compared++;
        if (timed_out || obs_data.size() != 8) begin
            mismatched++; $display("FAIL stall_count: timeout=%b words=%0d required 0/8", timed_out, obs_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < 8; i++) begin
            compared++;
            if (obs_data[i] !== bank_val(model_addr(base, 1, i), salt) || obs_last[i] !== (i == 7)) begin
                mismatched++; $display("FAIL stall_word[%0d]: got %h last %b required %h last %b", i, obs_data[i], obs_last[i], bank_val(model_addr(base, 1, i), salt), (i == 7));
            end
        end
        compared++;
        if (stall_err != 0 || mux_err != 0 || idle_err != 0) begin
            mismatched++; $display("FAIL stall_hold: stall_err %0d mux_err %0d idle_err %0d required 0/0/0", stall_err, mux_err, idle_err);
        end
        $display("stall: len=8 ready 1001 words=%0d done=%0d", obs_data.size(), done_cyc);
    endtask

    task automatic test_len0();
        run_cmd(10'h055, 11'd0, 2'd3, 10'd1, 0, 20);
        compared++;
        if (!accepted_ok || obs_addr.size() != 0 || obs_data.size() != 0 || done_cyc != 1 || idle_err != 0) begin
            mismatched++; $display("FAIL len0: accepted %b reads %0d words %0d idle at %0d idle_err %0d required 1/0/0/1/0",
                                   accepted_ok, obs_addr.size(), obs_data.size(), done_cyc, idle_err);
        end
        $display("len0: reads=%0d words=%0d", obs_addr.size(), obs_data.size());
    endtask

    task automatic test_reset_midcmd();
        int n_rd, cyc, stale;
        salt = $urandom;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 10'h100; cmd_len = 11'd16; cmd_mux = 2'd2; out_ready = 1'b1;
        n_rd = 0; cyc = 0;
        while (n_rd < 3 && cyc < 20) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
            #1;
            if (rd_en) n_rd++;
        end
        compared++;
        if (n_rd != 3) begin mismatched++; $display("FAIL rstmid_reads: got %0d reads required 3", n_rd); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        salt = salt ^ 32'hFFFF_0000;
        #1;
        compared++;
        if (rd_en !== 1'b0 || rd_addr !== '0 || rd_muxcode !== 2'b00 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || out_data !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_outputs: got rd_en=%b rd_addr=%h mux=%h ov=%b ol=%b od=%h busy=%b crdy=%b required 0,0,0,0,0,0,0,1",
                     rd_en, rd_addr, rd_muxcode, out_valid, out_last, out_data, busy, cmd_ready);
        end
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid || rd_en || busy) stale++;
        end
        compared++;
        if (stale != 0) begin mismatched++; $display("FAIL rstmid_stale: got %0d active cycles after reset required 0", stale); end
        $display("reset_mid: reset after 3rd read, active cycles after=%0d", stale);
    endtask

    task automatic test_random();
        for (int c = 0; c < 8; c++) begin
            int base, len, errs;
            logic [1:0] mux;
            base = $urandom_range(0, 1023);
            len  = $urandom_range(1, 12);
            mux  = 2'($urandom_range(0, 3));
            salt = $urandom;
            run_cmd(A'(base), (A+1)'(len), mux, 10'd1, 2, 400);
            errs = 0;
            compared++;
            if (timed_out || obs_data.size() != len || obs_addr.size() != len) begin
                mismatched++; $display("FAIL rand%0d_count: timeout=%b reads=%0d words=%0d required 0/%0d/%0d", c, timed_out, obs_addr.size(), obs_data.size(), len, len);
            end
            for (int i = 0; i < obs_data.size() && i < len; i++) begin
                compared++;
                if (obs_data[i] !== bank_val(model_addr(base, 1, i), salt) || obs_last[i] !== (i == len - 1)) begin
                    mismatched++; errs++;
                    $display("FAIL rand%0d_word[%0d]: got %h last %b required %h last %b", c, i, obs_data[i], obs_last[i], bank_val(model_addr(base, 1, i), salt), (i == len - 1));
                end
            end
            compared++;
            if (stall_err != 0 || mux_err != 0 || idle_err != 0) begin
                mismatched++; $display("FAIL rand%0d_proto: stall_err %0d mux_err %0d idle_err %0d required 0/0/0", c, stall_err, mux_err, idle_err);
            end
            $display("random %0d: addr=%h len=%0d mux=%0d words=%0d errs=%0d", c, base, len, mux, obs_data.size(), errs);
        end
    endtask

    task automatic test_back_to_back();
        // Two commands with no idle gap; each must be complete and ordered.
        for (int c = 0; c < 2; c++) begin
            int base;
            base = 100 * (c + 1);
            salt = $urandom;
            run_cmd(A'(base), 11'd3, 2'd1, 10'd1, 0, 50);
            compared++;
            if (timed_out || obs_data.size() != 3 || obs_data[0] !== bank_val(A'(base), salt) || obs_last[2] !== 1'b1) begin
                mismatched++; $display("FAIL b2b%0d: words %0d first %h required 3 words first %h", c, obs_data.size(),
                                       (obs_data.size() > 0) ? obs_data[0] : '0, bank_val(A'(base), salt));
            end
            $display("back_to_back %0d: addr=%h words=%0d", c, base, obs_data.size());
        end
    endtask

`ifdef BANK_READER_STRIDE_EN
    task automatic test_stride();
        salt = $urandom;
        run_cmd(10'h000, 11'd5, 2'd2, 10'h100, 0, 100);
        compared++;
        if (timed_out || obs_addr.size() != 5 || obs_data.size() != 5) begin
            mismatched++; $display("FAIL stride_count: timeout=%b reads=%0d words=%0d required 0/5/5", timed_out, obs_addr.size(), obs_data.size());
        end
        for (int i = 0; i < obs_addr.size() && i < 5; i++) begin
            compared++;
            if (obs_addr[i] !== model_addr(0, 256, i)) begin
                mismatched++; $display("FAIL stride_addr[%0d]: got %h required %h", i, obs_addr[i], model_addr(0, 256, i));
            end
        end
        $display("stride: stride=100 len=5 reads=%0d", obs_addr.size());
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_len0();
        test_reset_midcmd();
        test_random();
        test_back_to_back();
`ifdef BANK_READER_STRIDE_EN
        test_stride();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bank_reader.md
BANK_READER -- requirements
Module: bank_reader

Interface
REQ-001 SHALL have parameter W, default 64, meaning data word width in bits.
REQ-002 SHALL have parameter A, default 10, meaning bank address width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_addr  input  A  start word address.
REQ-008 SHALL have port cmd_len  input  A+1  word count, range 0..2^A.
REQ-009 SHALL have port cmd_mux  input  2  read mux code, held for the whole command.
REQ-010 SHALL have port rd_en  output  1  bank read enable.
REQ-011 SHALL have port rd_addr  output  A  bank read address.
REQ-012 SHALL have port rd_muxcode  output  2  bank read mux code.
REQ-013 SHALL have port rd_word  input  W  bank read data, valid exactly 1 cycle after rd_en.
REQ-014 SHALL have port out_valid  output  1  stream word available.
REQ-015 SHALL have port out_ready  input  1  consumer accepts; transfer occurs when out_valid and out_ready are both high.
REQ-016 SHALL have port out_data  output  W  stream word.
REQ-017 SHALL have port out_last  output  1  marks the final word of the command.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement states IDLE, RUN and DRAIN; cmd_ready = 1 only in IDLE.
REQ-020 In IDLE, cmd accept SHALL latch addr, len and mux, and SHALL move to RUN (len>0) or stay IDLE (len=0); a len=0 command SHALL produce no reads and no output.
REQ-021 In RUN, the block SHALL issue one read per cycle (rd_en=1, rd_addr=current address) whenever credit holds.
REQ-022 Credit SHALL be defined as (fifo_count + inflight - pop) < 2, where pop is an out transfer in that cycle.
REQ-023 After each issue, the address SHALL advance by the stride, modulo 2^A (wrap from 2^A-1 to 0), and the remaining count SHALL decrement.
REQ-024 When the last read is issued, the state SHALL move to DRAIN.
REQ-025 DRAIN SHALL return to IDLE on the cycle the last word transfers on the output, with no in-flight read and the FIFO empty.
REQ-026 rd_word SHALL be captured into a 2-entry FIFO on the cycle after issue, so that out_valid rises 2 cycles after the first rd_en.
REQ-027 The FIFO SHALL never overflow and SHALL never drop or duplicate words under any out_ready pattern.
REQ-028 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-029 out_data, out_last and out_valid SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 With out_ready held high, sustained throughput SHALL be 1 word/cycle.
REQ-031 out_last SHALL be 1 only on the word issued with remaining count 1.
REQ-032 rd_muxcode SHALL equal the latched cmd_mux while busy, and 0 in IDLE.
REQ-033 rd_en SHALL be 0 outside RUN.

Reset
REQ-034 On rst=1 at a clk edge, the block SHALL enter IDLE with the FIFO emptied and inflight cleared.
REQ-035 After reset, outputs SHALL be: rd_en=0, rd_addr=0, rd_muxcode=0, out_valid=0, out_last=0, out_data=0, busy=0, cmd_ready=1 from the cycle after release.
REQ-036 A read in flight when reset is asserted SHALL be discarded; its rd_word SHALL never appear on out_data.

Configuration
REQ-037 With macro BANK_READER_STRIDE_EN defined, the block SHALL add input port cmd_stride (A bits), latch it on cmd accept, and use it as the address increment (stride 0 re-reads the same address).
REQ-038 Without BANK_READER_STRIDE_EN, the cmd_stride port SHALL be absent and the stride SHALL be fixed at 1.

Verification
REQ-039 Bench SHALL cover: addr=0x010, len=4, out_ready=1 -> rd_addr 0x010..0x013 on 4 consecutive cycles; out_valid 2 cycles after the first rd_en; 4 back-to-back words; out_last on the 4th; busy falls after it.
REQ-040 Bench SHALL cover: addr=0x3FE, len=4 -> rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-041 Bench SHALL cover: len=8 with out_ready toggling 1,0,0,1 repeatedly -> exactly 8 words in order, no FIFO overflow, data held during stalls.
REQ-042 Bench SHALL cover: len=0 -> no rd_en, no out_valid, cmd_ready high again next cycle.
REQ-043 Bench SHALL cover: rst asserted 1 cycle after the 3rd rd_en of a len=16 command -> all outputs return to reset values and the stale rd_word is never output.
REQ-044 Bench SHALL cover, with BANK_READER_STRIDE_EN: addr=0, stride=0x100, len=5 -> rd_addr 0x000, 0x100, 0x200, 0x300, 0x000.
